// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: request/response bundle for one data-memory requester
interface dmem_arbiter_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int BEWIDTH = 4
);
  logic valid;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] wdata;
  logic [BEWIDTH-1:0] be;
  logic ready;
  logic rvalid;
  logic [DWIDTH-1:0] rdata;
  logic err;
  modport master (output valid, addr, wdata, be, input ready, rvalid, rdata, err);
  modport slave (input valid, addr, wdata, be, output ready, rvalid, rdata, err);
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port front end for data_memory with fixed-latency read return
module dmem_arbiter #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int BEWIDTH = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst,
  dmem_arbiter_if.slave      p0,
  dmem_arbiter_if.slave      p1,
  output logic [AWIDTH-1:0]  mem_addr,
  output logic [DWIDTH-1:0]  mem_wdata,
  output logic [BEWIDTH-1:0] mem_wren,
  input  logic [DWIDTH-1:0]  mem_rdata
);
  typedef struct packed {
    logic v;
    logic port;
    logic err;
    logic [DWIDTH-1:0] data;
  } rsp_t;
  logic prio_q, prio_d, g0, g1, mis;
  logic [BEWIDTH-1:0] be;
  rsp_t pipe_q [RD_LATENCY];
  rsp_t pipe_d [RD_LATENCY];
  rsp_t rsp;
  always_comb begin
    g0 = rst && p0.valid && (!p1.valid || !prio_q);
    g1 = rst && p1.valid && (!p0.valid || prio_q);
    mem_addr = g0 ? p0.addr : g1 ? p1.addr : '0;
    mem_wdata = g0 ? p0.wdata : g1 ? p1.wdata : '0;
    be = g0 ? p0.be : g1 ? p1.be : '0;
    mis = |mem_addr[1:0];
    mem_wren = mis ? '0 : be;
    prio_d = (g0 || g1) ? g0 : prio_q;
    pipe_d[0] = '{v: (g0 || g1) && (mis || be == '0), port: g1, err: mis, data: mis ? '0 : mem_rdata};
    for (int i = 1; i < RD_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
    rsp = pipe_q[RD_LATENCY-1];
    p0.ready = g0;
    p1.ready = g1;
    p0.rvalid = rst && rsp.v && !rsp.port;
    p1.rvalid = rst && rsp.v && rsp.port;
    p0.rdata = p0.rvalid ? rsp.data : '0;
    p1.rdata = p1.rvalid ? rsp.data : '0;
    p0.err = p0.rvalid && rsp.err;
    p1.err = p1.rvalid && rsp.err;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      prio_q <= 1'b0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      prio_q <= prio_d;
      pipe_q <= pipe_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter at read latencies 1, 2 and 3
module tb_dmem_arbiter;
  typedef struct {int due; bit port; bit err; logic [31:0] data;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic p0_valid = 1'b0, p1_valid = 1'b0;
  logic [31:0] p0_addr = '0, p1_addr = '0, p0_wdata = '0, p1_wdata = '0;
  logic [3:0] p0_be = '0, p1_be = '0;
  logic [31:0] ma [3], mw [3], mr [3], rd0 [3], rd1 [3];
  logic [3:0] wr [3];
  logic rdy0 [3], rdy1 [3], rv0 [3], rv1 [3], er0 [3], er1 [3];
  logic [31:0] dmem [3][64];
  logic [31:0] ref_mem [64];
  exp_t q [3][$];
  bit prio, acc0, acc1;
  int cyc, vectors, miscompares;
  always #5 clk = ~clk;
  for (genvar k = 0; k < 3; k++) begin : g
    dmem_arbiter_if a0 ();
    dmem_arbiter_if a1 ();
    assign a0.valid = p0_valid;
    assign a0.addr = p0_addr;
    assign a0.wdata = p0_wdata;
    assign a0.be = p0_be;
    assign a1.valid = p1_valid;
    assign a1.addr = p1_addr;
    assign a1.wdata = p1_wdata;
    assign a1.be = p1_be;
    dmem_arbiter #(.RD_LATENCY(k + 1)) u (
      .clk(clk), .rst(rst), .p0(a0), .p1(a1),
      .mem_addr(ma[k]), .mem_wdata(mw[k]), .mem_wren(wr[k]), .mem_rdata(mr[k])
    );
    assign rdy0[k] = a0.ready;
    assign rdy1[k] = a1.ready;
    assign rv0[k] = a0.rvalid;
    assign rv1[k] = a1.rvalid;
    assign rd0[k] = a0.rdata;
    assign rd1[k] = a1.rdata;
    assign er0[k] = a0.err;
    assign er1[k] = a1.err;
    assign mr[k] = dmem[k][ma[k][7:2]];
  end
  task automatic poke(input int w, input logic [31:0] v);
    ref_mem[w] = v;
    for (int k = 0; k < 3; k++) dmem[k][w] = v;
  endtask
  task automatic idle();
    p0_valid = 1'b0;
    p1_valid = 1'b0;
  endtask
  task automatic req(input bit port, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
    if (port) begin
      p1_valid = 1'b1; p1_addr = addr; p1_be = be; p1_wdata = wd;
    end else begin
      p0_valid = 1'b1; p0_addr = addr; p0_be = be; p0_wdata = wd;
    end
  endtask
  task automatic step();
    bit any, gp, mis, r, v0, v1, ee;
    logic [31:0] addr, wd, dat, ed;
    logic [3:0] be, ewr;
    logic [31:0] sa [3], sw [3];
    logic [3:0] swr [3];
    exp_t e;
    @(negedge clk);
    r = rst;
    any = r && (p0_valid || p1_valid);
    gp = (p0_valid && p1_valid) ? prio : p1_valid;
    addr = !any ? 32'h0 : gp ? p1_addr : p0_addr;
    wd = !any ? 32'h0 : gp ? p1_wdata : p0_wdata;
    be = !any ? 4'h0 : gp ? p1_be : p0_be;
    mis = addr[1:0] != 2'b00;
    ewr = mis ? 4'h0 : be;
    dat = mis ? 32'h0 : ref_mem[addr[7:2]];
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (rdy0[k] !== (any && !gp) || rdy1[k] !== (any && gp)) begin
        miscompares++;
        $display("FAIL ready L%0d cyc %0d: got p0=%b p1=%b want p0=%b p1=%b", k + 1, cyc, rdy0[k], rdy1[k], any && !gp, any && gp);
      end
      vectors++;
      if (ma[k] !== addr || mw[k] !== wd || wr[k] !== ewr) begin
        miscompares++;
        $display("FAIL mem_drive L%0d cyc %0d: got %h/%h/%h want %h/%h/%h", k + 1, cyc, ma[k], mw[k], wr[k], addr, wd, ewr);
      end
      if (!r) begin
        vectors++;
        if (rv0[k] !== 1'b0 || rv1[k] !== 1'b0 || rd0[k] !== 32'h0 || rd1[k] !== 32'h0 || er0[k] !== 1'b0 || er1[k] !== 1'b0) begin
          miscompares++;
          $display("FAIL reset_outputs L%0d: got rvalid %b%b err %b%b rdata %h %h want all zero", k + 1, rv0[k], rv1[k], er0[k], er1[k], rd0[k], rd1[k]);
        end
      end
      sa[k] = ma[k];
      sw[k] = mw[k];
      swr[k] = wr[k];
    end
    acc0 = any && !gp;
    acc1 = any && gp;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 3; k++)
      for (int b = 0; b < 4; b++)
        if (swr[k][b] === 1'b1) dmem[k][sa[k][7:2]][8*b +: 8] = sw[k][8*b +: 8];
    if (!r) begin
      prio = 1'b0;
      for (int k = 0; k < 3; k++) q[k].delete();
    end else if (any) begin
      prio = !gp;
      if (mis || be == 4'h0) begin
        for (int k = 0; k < 3; k++) begin
          e.due = cyc + k; e.port = gp; e.err = mis; e.data = dat;
          q[k].push_back(e);
        end
      end else begin
        for (int b = 0; b < 4; b++) if (be[b]) ref_mem[addr[7:2]][8*b +: 8] = wd[8*b +: 8];
      end
    end
    for (int k = 0; k < 3; k++) begin
      v0 = 1'b0; v1 = 1'b0; ee = 1'b0; ed = 32'h0;
      if (q[k].size() > 0 && q[k][0].due == cyc) begin
        e = q[k].pop_front();
        v0 = !e.port; v1 = e.port; ee = e.err; ed = e.data;
      end
      vectors++;
      if (rv0[k] !== v0 || rd0[k] !== (v0 ? ed : 32'h0) || er0[k] !== (v0 && ee)) begin
        miscompares++;
        $display("FAIL p0_rsp L%0d cyc %0d: got v=%b d=%h e=%b want v=%b d=%h e=%b", k + 1, cyc, rv0[k], rd0[k], er0[k], v0, v0 ? ed : 32'h0, v0 && ee);
      end
      vectors++;
      if (rv1[k] !== v1 || rd1[k] !== (v1 ? ed : 32'h0) || er1[k] !== (v1 && ee)) begin
        miscompares++;
        $display("FAIL p1_rsp L%0d cyc %0d: got v=%b d=%h e=%b want v=%b d=%h e=%b", k + 1, cyc, rv1[k], rd1[k], er1[k], v1, v1 ? ed : 32'h0, v1 && ee);
      end
    end
  endtask
  task automatic do_reset();
    idle();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask
  task automatic test_reset();
    rst = 1'b0;
    req(0, 32'h4, 4'h0, 32'h0);
    req(1, 32'h8, 4'h0, 32'h0);
    #1;
    vectors++;
    if (rdy0[0] !== 1'b0 || rdy1[0] !== 1'b0 || wr[0] !== 4'h0 || ma[0] !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_ready: got rdy %b%b wren %h addr %h want 0 0 0 0", rdy0[0], rdy1[0], wr[0], ma[0]);
    end
    step();
    step();
    idle();
    rst = 1'b1;
    step();
  endtask
  task automatic test_single_read();
    do_reset();
    poke(4, 32'hCAFEF00D);
    req(0, 32'h10, 4'h0, 32'h0);
    #1;
    vectors++;
    if (rdy0[0] !== 1'b1 || rdy1[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL single_read_ready: got %b%b want 10", rdy0[0], rdy1[0]);
    end
    step();
    idle();
    vectors++;
    if (rv0[0] !== 1'b1 || rd0[0] !== 32'hCAFEF00D || rv1[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL single_read_rsp: got v=%b d=%h v1=%b want 1 cafef00d 0", rv0[0], rd0[0], rv1[0]);
    end
    step();
  endtask
  task automatic test_contention();
    logic [31:0] want;
    do_reset();
    req(0, 32'h0, 4'h0, 32'h0);
    req(1, 32'h40, 4'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      want = (i % 2 == 0) ? p0_addr : p1_addr;
      vectors++;
      if (rdy0[0] !== (i % 2 == 0) || rdy1[0] !== (i % 2 == 1) || ma[0] !== want) begin
        miscompares++;
        $display("FAIL contention %0d: got rdy %b%b addr %h want rdy %b%b addr %h", i, rdy0[0], rdy1[0], ma[0], i % 2 == 0, i % 2 == 1, want);
      end
      step();
      if (acc0) p0_addr = p0_addr + 4;
      if (acc1) p1_addr = p1_addr + 4;
    end
    idle();
    step();
  endtask
  task automatic test_partial_write();
    idle();
    poke(8, 32'h12345678);
    req(1, 32'h20, 4'b0011, 32'hAAAA5555);
    step();
    idle();
    req(0, 32'h20, 4'h0, 32'h0);
    step();
    idle();
    vectors++;
    if (rv0[0] !== 1'b1 || rd0[0] !== 32'h12345555) begin
      miscompares++;
      $display("FAIL partial_write: got v=%b d=%h want 1 12345555", rv0[0], rd0[0]);
    end
    step();
  endtask
  task automatic test_misaligned();
    req(0, 32'h22, 4'hF, 32'hFFFFFFFF);
    #1;
    vectors++;
    if (rdy0[0] !== 1'b1 || wr[0] !== 4'h0) begin
      miscompares++;
      $display("FAIL misaligned_wren: got rdy=%b wren=%h want 1 0", rdy0[0], wr[0]);
    end
    step();
    idle();
    vectors++;
    if (rv0[0] !== 1'b1 || er0[0] !== 1'b1 || rd0[0] !== 32'h0 || dmem[0][8] !== 32'h12345555) begin
      miscompares++;
      $display("FAIL misaligned_rsp: got v=%b e=%b d=%h mem=%h want 1 1 0 12345555", rv0[0], er0[0], rd0[0], dmem[0][8]);
    end
    step();
  endtask
  task automatic test_reset_flush();
    idle();
    req(0, 32'h10, 4'h0, 32'h0);
    step();
    idle();
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (rv0[1] !== 1'b0 || rv1[1] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_flush %0d: got rvalid %b%b want 00", i, rv0[1], rv1[1]);
      end
    end
    req(0, 32'h4, 4'h0, 32'h0);
    req(1, 32'h8, 4'h0, 32'h0);
    #1;
    vectors++;
    if (rdy0[0] !== 1'b1 || rdy1[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_prio: got rdy %b%b want 10", rdy0[0], rdy1[0]);
    end
    step();
    idle();
    step();
  endtask
  task automatic test_back_to_back_l3();
    logic [31:0] vals [5];
    bit want;
    idle();
    step();
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      vals[i] = $urandom;
      poke(i, vals[i]);
    end
    for (int i = 0; i < 9; i++) begin
      if (i < 5) req(0, 32'(4 * i), 4'h0, 32'h0);
      else idle();
      step();
      want = i >= 2 && i < 7;
      vectors++;
      if (rv0[2] !== want || (want && rd0[2] !== vals[want ? i - 2 : 0])) begin
        miscompares++;
        $display("FAIL back_to_back_l3 %0d: got v=%b d=%h want v=%b d=%h", i, rv0[2], rd0[2], want, want ? vals[i - 2] : 32'h0);
      end
    end
  endtask
  task automatic rand_req(input bit port);
    logic [31:0] addr;
    addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
    if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
    req(port, addr, $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15)), $urandom);
  endtask
  task automatic test_random();
    idle();
    for (int i = 0; i < 500; i++) begin
      if (!p0_valid || acc0) begin
        if ($urandom_range(0, 9) < 7) rand_req(0);
        else p0_valid = 1'b0;
      end
      if (!p1_valid || acc1) begin
        if ($urandom_range(0, 9) < 7) rand_req(1);
        else p1_valid = 1'b0;
      end
      rst = $urandom_range(0, 79) != 0;
      step();
    end
    rst = 1'b1;
    idle();
    for (int i = 0; i < 4; i++) step();
  endtask
  initial begin
    for (int w = 0; w < 64; w++) poke(w, $urandom);
    test_reset();
    test_single_read();
    test_contention();
    test_partial_write();
    test_misaligned();
    test_reset_flush();
    test_back_to_back_l3();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
